pwm_modulator: RTL

Three-phase center-aligned PWM modulator with dead-time insertion. It consumes the up/down triangular carrier count and compares it against per-phase duty words taken through a valid/ready handshake. It produces complementary high-side/low-side gate drives for the inverter bridge. It sits between the FOC duty computation (SVPWM output) and the gate-driver pins.

---
 rtl/foc_pwm_pkg.sv | 17 +
 rtl/pwm_modulator_dead_time_gen.sv | 79 +++++++
 rtl/pwm_modulator.sv | 110 +++++++++++
 3 files changed

// File: rtl/foc_pwm_pkg.sv
// Shared types for the three-phase center-aligned PWM modulator.
// Phase states, phase count and the duty triple bundle.
package foc_pwm_pkg;

  localparam int NUM_PHASES = 3;
  localparam int PWM_N      = 6;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_HI,
    PH_LO,
    PH_DEAD
  } phase_state_e;

  typedef logic [NUM_PHASES-1:0][PWM_N-1:0] duty_triple_t;

endpackage

// File: rtl/pwm_modulator_dead_time_gen.sv
// Per-phase dead-time generator: complementary gate pair from one raw compare bit.
// Both sides stay low for dead_time+1 cycles around every side change.
module dead_time_gen
  import foc_pwm_pkg::*;
#(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            raw,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  output logic            hi,
  output logic            lo
);

  phase_state_e    state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            tgt_q, tgt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    if (!en) begin
      state_d = PH_OFF;
    end else begin
      unique case (state_q)
        PH_OFF: begin
          state_d = PH_DEAD;
          cnt_d   = dead_time;
          tgt_d   = raw;
        end
        PH_HI: begin
          if (!raw) begin
            state_d = PH_DEAD;
            cnt_d   = dead_time;
            tgt_d   = 1'b0;
          end
        end
        PH_LO: begin
          if (raw) begin
            state_d = PH_DEAD;
            cnt_d   = dead_time;
            tgt_d   = 1'b1;
          end
        end
        PH_DEAD: begin
          // a flip while blanking restarts the full gap
          if (raw != tgt_q) begin
            cnt_d = dead_time;
            tgt_d = raw;
          end else if (cnt_q == '0) begin
            state_d = raw ? PH_HI : PH_LO;
          end else begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        default: state_d = PH_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= PH_DEAD;
      cnt_q   <= '0;
      tgt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign hi = (state_q == PH_HI);
  assign lo = (state_q == PH_LO);

endmodule

// File: rtl/pwm_modulator.sv
// Three-phase center-aligned PWM: duty handshake, valley shadow load, compare.
// Optional PWM_FAULT_EN adds a synchronized, latched gate-kill input.
module pwm_modulator
  import foc_pwm_pkg::*;
#(
  parameter int N    = PWM_N,
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [N-1:0]    carrier,
  input  logic [N-1:0]    duty_a,
  input  logic [N-1:0]    duty_b,
  input  logic [N-1:0]    duty_c,
  input  logic            duty_valid,
  output logic            duty_ready,
  input  logic [DT_W-1:0] dead_time,
  output logic [2:0]      gate_hi,
  output logic [2:0]      gate_lo,
`ifdef PWM_FAULT_EN
  input  logic            fault_n,
  input  logic            fault_clr,
  output logic            fault,
`endif
  output logic            sync
);

  duty_triple_t    pend_q, pend_d;
  duty_triple_t    act_q, act_d;
  logic            pend_full_q, pend_full_d;
  logic [NUM_PHASES-1:0] raw_q, raw_d;
  logic            sync_q, sync_d;
  logic            hs, load, block, ph_en;

`ifdef PWM_FAULT_EN
  logic fsync1_q, fsync2_q;
  logic fault_q, fault_d;

  // set wins over clear while the synchronized input is still low
  always_comb begin
    fault_d = !fsync2_q | (fault_q & !(fault_clr & fsync2_q));
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fsync1_q <= 1'b1;
      fsync2_q <= 1'b1;
      fault_q  <= 1'b0;
    end else begin
      fsync1_q <= fault_n;
      fsync2_q <= fsync1_q;
      fault_q  <= fault_d;
    end
  end

  assign block = fault_d;
  assign fault = fault_q;
`else
  assign block = 1'b0;
`endif

  always_comb begin
    hs          = duty_valid & !pend_full_q;
    load        = en & !block & (carrier == '0) & pend_full_q;
    pend_d      = hs ? {duty_c, duty_b, duty_a} : pend_q;
    pend_full_d = hs | (pend_full_q & !load);
    act_d       = load ? pend_q : act_q;
    sync_d      = load;
    raw_d       = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      raw_d[i] = act_d[i] > carrier;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q      <= '0;
      act_q       <= '0;
      pend_full_q <= 1'b0;
      raw_q       <= '0;
      sync_q      <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      act_q       <= act_d;
      pend_full_q <= pend_full_d;
      raw_q       <= raw_d;
      sync_q      <= sync_d;
    end
  end

  assign ph_en      = en & !block;
  assign duty_ready = !pend_full_q;
  assign sync       = sync_q;

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_ph
    dead_time_gen #(
      .DT_W(DT_W)
    ) u_dt (
      .clk      (clk),
      .nrst     (nrst),
      .raw      (raw_q[g]),
      .en       (ph_en),
      .dead_time(dead_time),
      .hi       (gate_hi[g]),
      .lo       (gate_lo[g])
    );
  end

endmodule
